line_writeback_packer: RTL and testbench
========================================

// Module: line_writeback_packer
// PURPOSE
//  Write-side counterpart of the column line buffers. Collects processed 16-pixel column strips
//  (e.g. blurred / DoG results) and packs them into full 640-pixel SRAM row words.
//  Two row banks form a ping-pong pair: one bank fills while the other is written back to SRAM.
//  Sits between a working module's output stage and the SRAM write port.
// PARAMETERS
//  PIX_W      8    bits per pixel
//  STRIP_PIX  16   pixels per input strip; STRIP_W = PIX_W*STRIP_PIX = 128
//  ROW_PIX    640  pixels per row; ROW_W = 5120; COLS = ROW_PIX/STRIP_PIX = 40
//  ROWS       480  rows per frame
// PORTS
//  clk        in   1     clock, all state on posedge
//  rst        in   1     synchronous, active-high reset
//  start      in   1     frame start: same effect as rst, for one cycle
//  in_valid   in   1     strip valid
//  in_ready   out  1     strip accepted when in_valid && in_ready
//  in_data    in   128   strip: pixel k at bits [8k+7:8k]
//  in_col     in   6     strip column index, 0..COLS-1
//  wr_valid   out  1     row word ready for SRAM
//  wr_ready   in   1     SRAM accepts row when wr_valid && wr_ready
//  wr_data    out  5120  packed row: strip c at bits [128c+127:128c]
//  wr_addr    out  9     SRAM row address, 0..ROWS-1
//  frame_done out  1     1-cycle pulse after row ROWS-1 is accepted
//  col_err    out  1     sticky: a strip with in_col >= COLS was received
// BEHAVIOUR
//  State: bank0/bank1 (5120b each), full[1:0], fill_sel, drain_sel, row_addr, col_err.
//  Reset (rst or start): banks = 0; full = 0; fill_sel = drain_sel = 0; row_addr = 0; col_err = 0.
//    Resulting outputs: wr_valid = 0, frame_done = 0, in_ready = 1.
//  Reset mid-operation discards any partial or pending rows; there is no SRAM write for them.
//  in_ready = !full[fill_sel]. It is combinational from state only, never from in_valid.
//  Accept, in_col < COLS: strip written into bank[fill_sel] at slot in_col; other slots are kept.
//    A repeated column overwrites the earlier strip.
//  Accept, in_col >= COLS: data dropped; col_err <= 1. The strip counts as consumed.
//  Row completes on accept of in_col == COLS-1: full[fill_sel] <= 1, fill_sel toggles.
//    Columns are not counted: any slot never written stays 0 (zero fill).
//  wr_valid = full[drain_sel]; wr_data = bank[drain_sel]; wr_addr = row_addr.
//    All three are held stable while wr_valid && !wr_ready.
//  Drain (wr_valid && wr_ready): bank[drain_sel] <= 0, full[drain_sel] <= 0, drain_sel toggles.
//    row_addr increments; it wraps ROWS-1 -> 0, and at the wrap frame_done = 1 next cycle.
//  Latency: last strip accepted in cycle N -> wr_valid = 1 in cycle N+1, if the drain bank is
//    empty.
//  Completion and drain in the same cycle touch different banks; both take effect.
//  When fill_sel == drain_sel and that bank drains in the same cycle, in_ready rises in the next
//    cycle. There is no same-cycle bypass.
//  Both banks full: in_ready = 0 until one drain. Throughput is 1 strip/cycle with no
//    backpressure.
//  start has priority over all accept/drain activity in the same cycle.
// TESTING
//  1 rst, send cols 0..39 data={16{col[7:0]}} with wr_ready=1 -> one wr_valid cycle,
//    wr_addr=0, slot c bytes = c.
//  2 Hold wr_ready=0, send 3 full rows -> in_ready=0 after row 2; wr_data/wr_addr stable;
//    release -> rows 0,1,2 drain in order, then in_ready=1.
//  3 Send only cols 5 and 39 -> wr_data zero except slots 5 and 39; next row again zero except
//    the cols written to it.
//  4 Send col 7 twice (0xAA.., then 0x55..), then col 39 -> slot 7 = 0x55..; in_col=45 ->
//    col_err=1, no wr_valid.
//  5 Drain 480 rows -> wr_addr 0..479 then 0; frame_done high exactly 1 cycle after the 480th
//    accept.
//  6 Assert start while a row is pending and another is half-filled -> next cycle wr_valid=0,
//    in_ready=1, col_err=0, and the next row uses wr_addr=0.

Source files
------------

// File: rtl/line_writeback_packer.sv
// Packs 16-pixel column strips into 640-pixel SRAM row words through a ping-pong pair of row banks.
// Row valid one cycle after its last strip; in_ready drops only while both banks hold undrained rows.
module line_writeback_packer #(
  parameter  int PIX_W     = 8,
  parameter  int STRIP_PIX = 16,
  parameter  int ROW_PIX   = 640,
  parameter  int ROWS      = 480,
  localparam int STRIP_W   = PIX_W * STRIP_PIX,
  localparam int ROW_W     = PIX_W * ROW_PIX,
  localparam int COLS      = ROW_PIX / STRIP_PIX,
  localparam int COL_W     = $clog2(COLS),
  localparam int ADDR_W    = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STRIP_W-1:0] in_data,
  input  logic [COL_W-1:0]   in_col,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ROW_W-1:0]   wr_data,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               frame_done,
  output logic               col_err
);

  localparam logic [COL_W-1:0]  NUM_COLS = COL_W'(COLS);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  logic [COLS-1:0][STRIP_W-1:0] bank [2];
  logic [1:0]                   full;
  logic                         fill_sel;
  logic                         drain_sel;
  logic [ADDR_W-1:0]            row_addr;
  logic                         accept;
  logic                         drain;

  assign in_ready = !full[fill_sel];
  assign wr_valid = full[drain_sel];
  assign wr_data  = bank[drain_sel];
  assign wr_addr  = row_addr;
  assign accept   = in_valid && in_ready;
  assign drain    = wr_valid && wr_ready;

  // Accept and drain never target the same bank: accept needs it empty, drain needs it full.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      bank[0]    <= '0;
      bank[1]    <= '0;
      full       <= 2'b00;
      fill_sel   <= 1'b0;
      drain_sel  <= 1'b0;
      row_addr   <= '0;
      col_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        if (in_col < NUM_COLS) begin
          bank[fill_sel][in_col] <= in_data;
        end else begin
          col_err <= 1'b1;
        end
        if (in_col == LAST_COL) begin
          full[fill_sel] <= 1'b1;
          fill_sel       <= !fill_sel;
        end
      end
      if (drain) begin
        bank[drain_sel] <= '0;
        full[drain_sel] <= 1'b0;
        drain_sel       <= !drain_sel;
        if (row_addr == LAST_ROW) begin
          row_addr   <= '0;
          frame_done <= 1'b1;
        end else begin
          row_addr <= row_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_line_writeback_packer.sv
// Directed bench for line_writeback_packer: row assembly, backpressure, zero fill, overwrite,
// frame wrap and start-abort, with expected rows built independently by the bench.
module tb_line_writeback_packer;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [5:0]    in_col;
  logic          wr_valid;
  logic          wr_ready;
  logic [5119:0] wr_data;
  logic [8:0]    wr_addr;
  logic          frame_done;
  logic          col_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [5119:0] dq[$];
  logic [8:0]    aq[$];
  int            dc[$];
  int            fd_cnt = 0;
  int            fd_cyc = -1;

  line_writeback_packer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_col     (in_col),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_addr    (wr_addr),
    .frame_done (frame_done),
    .col_err    (col_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Inputs change just after posedge, so the negedge view matches what the next edge sees.
  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      dq.push_back(wr_data);
      aq.push_back(wr_addr);
      dc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] strip(input logic [7:0] v);
    return {16{v}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    dq.delete();
    aq.delete();
    dc.delete();
    fd_cnt = 0;
    fd_cyc = -1;
  endtask

  task automatic send_strip(input logic [5:0] col, input logic [127:0] d);
    int w = 0;
    in_valid = 1'b1;
    in_col   = col;
    in_data  = d;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout col=%0d: in_ready stayed 0, required 1", col);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_row(input logic [7:0] tag);
    for (int c = 0; c < 40; c++) send_strip(6'(c), strip(8'(tag + c)));
  endtask

  task automatic wait_drains(input int n);
    int w = 0;
    while (dq.size() < n && w < 2000) begin
      tick();
      w++;
    end
    if (dq.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: saw %0d drains, required %0d", dq.size(), n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_col = '0; in_data = '0; wr_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (col_err !== 1'b0) begin n_fail++; $display("FAIL reset_col_err got %b want 0", col_err); end
  endtask

  task automatic test_full_row;
    logic [5119:0] exp = '0;
    clear_mon();
    wr_ready = 1'b1;
    for (int c = 0; c < 40; c++) exp[c*128 +: 128] = strip(8'(c));
    send_row(8'h00);
    n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL row_latency wr_valid got %b want 1", wr_valid); end
    n_checks++; if (wr_addr !== 9'd0) begin n_fail++; $display("FAIL row_addr got %0d want 0", wr_addr); end
    n_checks++; if (wr_data !== exp) begin n_fail++; $display("FAIL row_data got %h want %h", wr_data[255:0], exp[255:0]); end
    tick(); tick();
    n_checks++; if (dq.size() !== 1) begin n_fail++; $display("FAIL row_drain_count got %0d want 1", dq.size()); end
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL row_after_drain wr_valid got %b want 0", wr_valid); end
  endtask

  task automatic test_backpressure;
    logic [5119:0] ra = '0, rb = '0, rc = '0;
    int bad = 0;
    for (int c = 0; c < 40; c++) begin
      ra[c*128 +: 128] = strip(8'(8'h40 + c));
      rb[c*128 +: 128] = strip(8'(8'h80 + c));
      rc[c*128 +: 128] = strip(8'(8'hC0 + c));
    end
    clear_mon();
    wr_ready = 1'b0;
    send_row(8'h40);
    send_row(8'h80);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    n_checks++; if (wr_addr !== 9'd1 || wr_data !== ra) begin n_fail++; $display("FAIL bp_hold addr got %0d want 1", wr_addr); end
    tick(); tick(); tick();
    n_checks++; if (wr_valid !== 1'b1 || wr_addr !== 9'd1 || wr_data !== ra) begin n_fail++; $display("FAIL bp_stable valid %b addr got %0d want 1", wr_valid, wr_addr); end
    fork
      send_row(8'hC0);
      begin
        repeat (5) tick();
        wr_ready = 1'b1;
      end
    join
    wait_drains(3);
    tick(); tick();
    for (int i = 0; i < 3 && i < aq.size(); i++) if (aq[i] !== 9'(1 + i)) bad++;
    n_checks++; if (bad != 0 || aq.size() != 3) begin n_fail++; $display("FAIL bp_order %0d bad addrs, %0d drains want 3", bad, aq.size()); end
    n_checks++; if (dq.size() != 3 || dq[0] !== ra || dq[1] !== rb || dq[2] !== rc) begin n_fail++; $display("FAIL bp_data drains %0d rows differ from rows A,B,C", dq.size()); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero_fill;
    logic [5119:0] e0 = '0, e1 = '0;
    e0[5*128 +: 128]  = strip(8'h5A);
    e0[39*128 +: 128] = strip(8'h39);
    e1[12*128 +: 128] = strip(8'h12);
    e1[39*128 +: 128] = strip(8'h93);
    clear_mon();
    wr_ready = 1'b1;
    send_strip(6'd5, strip(8'h5A));
    send_strip(6'd39, strip(8'h39));
    wait_drains(1);
    send_strip(6'd12, strip(8'h12));
    send_strip(6'd39, strip(8'h93));
    wait_drains(2);
    n_checks++; if (dq.size() < 1 || dq[0] !== e0 || aq[0] !== 9'd4) begin n_fail++; $display("FAIL zero_fill_row0 data/addr differs, want addr 4"); end
    n_checks++; if (dq.size() < 2 || dq[1] !== e1 || aq[1] !== 9'd5) begin n_fail++; $display("FAIL zero_fill_row1 data/addr differs, want addr 5"); end
  endtask

  task automatic test_overwrite_col_err;
    logic [5119:0] e = '0;
    e[7*128 +: 128]  = strip(8'h55);
    e[39*128 +: 128] = strip(8'h39);
    clear_mon();
    wr_ready = 1'b1;
    n_checks++; if (col_err !== 1'b0) begin n_fail++; $display("FAIL col_err_pre got %b want 0", col_err); end
    send_strip(6'd7, strip(8'hAA));
    send_strip(6'd7, strip(8'h55));
    send_strip(6'd39, strip(8'h39));
    wait_drains(1);
    n_checks++; if (dq.size() < 1 || dq[0] !== e || aq[0] !== 9'd6) begin n_fail++; $display("FAIL overwrite slot7 got %h want %h", dq.size() > 0 ? dq[0][7*128 +: 128] : 128'h0, e[7*128 +: 128]); end
    send_strip(6'd45, strip(8'hFF));
    tick(); tick(); tick();
    n_checks++; if (col_err !== 1'b1) begin n_fail++; $display("FAIL col_err got %b want 1", col_err); end
    n_checks++; if (dq.size() != 1 || wr_valid !== 1'b0) begin n_fail++; $display("FAIL col_err_no_write drains %0d want 1, wr_valid %b want 0", dq.size(), wr_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL col_err_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_frame_wrap;
    int bad = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    clear_mon();
    wr_ready = 1'b1;
    for (int r = 0; r < 480; r++) send_strip(6'd39, strip(8'(r)));
    wait_drains(480);
    tick(); tick(); tick();
    for (int i = 0; i < 480 && i < aq.size(); i++) if (aq[i] !== 9'(i)) bad++;
    n_checks++; if (bad != 0 || aq.size() != 480) begin n_fail++; $display("FAIL wrap_addrs %0d bad of %0d drains, want 0 bad of 480", bad, aq.size()); end
    n_checks++; if (fd_cnt != 1) begin n_fail++; $display("FAIL frame_done_count got %0d want 1", fd_cnt); end
    n_checks++; if (dc.size() < 480 || fd_cyc != dc[479] + 1) begin n_fail++; $display("FAIL frame_done_timing got cycle %0d want %0d", fd_cyc, dc.size() < 480 ? -1 : dc[479] + 1); end
    send_strip(6'd39, strip(8'hEE));
    wait_drains(481);
    n_checks++; if (aq.size() < 481 || aq[480] !== 9'd0) begin n_fail++; $display("FAIL wrap_next_addr got %0d want 0", aq.size() < 481 ? 9'h1FF : aq[480]); end
  endtask

  task automatic test_start_abort;
    logic [5119:0] e = '0;
    e[25*128 +: 128] = strip(8'h25);
    e[39*128 +: 128] = strip(8'h39);
    clear_mon();
    wr_ready = 1'b0;
    send_row(8'h20);
    for (int c = 0; c < 20; c++) send_strip(6'(c), strip(8'(8'h60 + c)));
    send_strip(6'd50, strip(8'hFF));
    n_checks++; if (wr_valid !== 1'b1 || col_err !== 1'b1) begin n_fail++; $display("FAIL pre_start wr_valid %b col_err %b want 1 1", wr_valid, col_err); end
    start = 1'b1; in_valid = 1'b1; in_col = 6'd39; in_data = '1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL start_wr_valid got %b want 0", wr_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_in_ready got %b want 1", in_ready); end
    n_checks++; if (col_err !== 1'b0) begin n_fail++; $display("FAIL start_col_err got %b want 0", col_err); end
    wr_ready = 1'b1;
    send_strip(6'd25, strip(8'h25));
    send_strip(6'd39, strip(8'h39));
    wait_drains(1);
    tick(); tick();
    n_checks++; if (dq.size() != 1 || aq[0] !== 9'd0 || dq[0] !== e) begin n_fail++; $display("FAIL start_next_row drains %0d want 1 at addr 0 with only slots 25,39", dq.size()); end
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_backpressure();
    test_zero_fill();
    test_overwrite_col_err();
    test_frame_wrap();
    test_start_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
